dr_handshake_ctrl: RTL and testbench
====================================

Name: dr_handshake_ctrl

Overview:
- Synchronous four-phase sequencer for a dual-rail combinational datapath, e.g. a comparator built from AND2_pdr/AO22_ndr-style cells with a cp0xx completion detector.
- Accepts single-rail operands on a valid/ready port and encodes them to dual-rail. Alternates data and spacer phases, pacing each phase from the detector's completion output.
- Decodes and returns the dual-rail result, and flags timeouts and illegal (1,1) rail codes.
- Sits between the clocked SoC fabric and the asynchronous dual-rail island.

Parameters:
- IN_W, 16, single-rail operand bits driven into the datapath (one dual-rail pair each)
- OUT_W, 2, result bits returned by the datapath (one dual-rail pair each)
- SYNC_STAGES, 2, flop stages on the asynchronous completion input (min 2)
- TIMEOUT, 255, max cycles spent waiting in DATA or SPACER before the error path
- CD_RST_CYC, 2, cycles cd_sdn is held low on (re)initialisation

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  operand accepted when in_valid & in_ready
- in_data  in  IN_W  operand word
- dr_in_1  out  IN_W  true rails to datapath
- dr_in_0  out  IN_W  false rails to datapath
- cd_q  in  1  completion detector output, asynchronous (1 = all rails valid, 0 = all spacer)
- cd_sdn  out  1  active-low reset to the detector C-element
- dr_out_1  in  OUT_W  datapath true rails, asynchronous
- dr_out_0  in  OUT_W  datapath false rails, asynchronous
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  OUT_W  decoded result (dr_out_1 sampled)
- out_err  out  1  result contained at least one illegal (1,1) pair
- err_timeout  out  1  sticky: a phase timed out
- err_clr  in  1  one-cycle pulse that clears err_timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - all-zero: dr_in_1, dr_in_0, out_data, out_valid, out_err, in_ready, err_timeout
  - cd_sdn = 0, busy = 1
  - state = CDRST, counter = 0
- Reset is asynchronous and active-high: while rst is high every register holds its reset value regardless of the clock.
- All outputs are registered. cd_q passes through SYNC_STAGES flops to give cd_s; dr_out_* are sampled only in CAPTURE.
- States:
  - CDRST: spacer driven, cd_sdn = 0 for CD_RST_CYC cycles, then cd_sdn = 1 and go to WAITSP.
  - WAITSP: spacer driven. When cd_s = 0, go to IDLE. Counter runs; expiry goes to ERR.
  - IDLE: in_ready = 1, busy = 0. On handshake, register dr_in_1 = in_data and dr_in_0 = ~in_data, then go to DATA. Rails change on the cycle after acceptance.
  - DATA: when cd_s = 1, go to CAPTURE. Counter runs from entry; cd_s = 1 on the expiry cycle wins over the timeout.
  - CAPTURE: one cycle.
    - out_data = dr_out_1.
    - out_err = |(dr_out_1 & dr_out_0).
    - out_valid = 1.
    - Go to HOLD.
  - HOLD: data rails stay driven. out_valid stays high until out_ready; on handshake out_valid = 0, rails go to spacer (all 0), go to SPACER.
  - SPACER: when cd_s = 0, go to IDLE. Counter runs; expiry goes to ERR.
  - ERR: one cycle.
    - err_timeout = 1.
    - Rails go to spacer.
    - out_valid = 0.
    - Go to CDRST.
- Counter clears on every state entry. Timeout fires when the count reaches TIMEOUT, i.e. on the TIMEOUT-th waiting cycle.
- Latency from acceptance to out_valid = 1 (rail register) + detector delay + SYNC_STAGES + 1 (CAPTURE) cycles.
- in_ready is low outside IDLE: no new operand enters until the spacer has been confirmed.
- The out_data/out_err pair holds its value from CAPTURE until the next CAPTURE.
- err_clr clears err_timeout. If err_clr coincides with a new timeout, set wins.
- out_valid never asserts without a preceding cd_s = 1 in the current DATA phase.

Decomposition:
- Package dr_ctrl_pkg holds:
  - the state enum (CDRST, WAITSP, IDLE, DATA, CAPTURE, HOLD, SPACER, ERR)
  - function dr_encode(word) returning {rail1, rail0}
  - function dr_illegal(rail1, rail0)
- Sub-module dr_cd_sync: SYNC_STAGES-deep synchroniser with asynchronous reset to 0.
- The FSM, counter and datapath registers live in the top module.

Test Plan:
- Reset and init: rst for 3 cycles with cd_q = 0. Required: cd_sdn low for 2 cycles after release, then high; IDLE reached after 2 sync cycles; in_ready = 1; rails all 0.
- Nominal transfer: detector model raises cd_q 3 cycles after the rails, with dr_out_1 = 2'b10 and dr_out_0 = 2'b01. Accept in_data = 16'hA5C3. Required:
  - dr_in_1 = A5C3 and dr_in_0 = 5A3C one cycle later
  - out_valid 7 cycles after acceptance
  - out_data = 2'b10, out_err = 0
- Backpressure: out_ready held low for 10 cycles. Required: out_valid stays 1, rails remain data, in_ready = 0. On release, rails go to spacer in the next cycle, and in_ready returns after cd_q falls plus 2 cycles.
- Illegal code: dr_out_1 = 2'b11, dr_out_0 = 2'b01. Required: out_err = 1, out_data = 2'b11, err_timeout stays 0.
- Timeout: cd_q never rises in DATA, TIMEOUT = 8. Required:
  - ERR entered after 8 waiting cycles
  - err_timeout = 1, rails go to 0, cd_sdn pulses low for 2 cycles
  - err_clr then clears err_timeout
- Reset mid-operation: rst asserted while in HOLD. Required: on the same edge, out_valid = 0, rails = 0, cd_sdn = 0, and the CDRST sequence restarts.

Source files
------------

// File: rtl/dr_ctrl_pkg.sv
// Shared types and dual-rail helpers for the dual-rail handshake controller.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package dr_ctrl_pkg;

    localparam int DR_MAX_W = 64;

    typedef enum logic [2:0] {
        CDRST,
        WAITSP,
        IDLE,
        DATA,
        CAPTURE,
        HOLD,
        SPACER,
        ERR
    } state_t;

    // Result is {rail1, rail0}: true rails carry the word, false rails its complement.
    function automatic logic [2*DR_MAX_W-1:0] dr_encode(input logic [DR_MAX_W-1:0] word);
        return {word, ~word};
    endfunction

    function automatic logic dr_illegal(input logic [DR_MAX_W-1:0] rail1,
                                        input logic [DR_MAX_W-1:0] rail0);
        return |(rail1 & rail0);
    endfunction

endpackage

// File: rtl/dr_cd_sync.sv
// Multi-flop synchroniser for the asynchronous completion-detector output.
module dr_cd_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/dr_handshake_ctrl.sv
// Four-phase sequencer bridging a valid/ready operand port to a dual-rail
// datapath, pacing data and spacer phases from the synchronised completion signal.
module dr_handshake_ctrl #(
    parameter int IN_W        = 16,
    parameter int OUT_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CD_RST_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic [IN_W-1:0]  dr_in_1,
    output logic [IN_W-1:0]  dr_in_0,
    input  logic             cd_q,
    output logic             cd_sdn,
    input  logic [OUT_W-1:0] dr_out_1,
    input  logic [OUT_W-1:0] dr_out_0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic             err_timeout,
    input  logic             err_clr,
    output logic             busy
);

    import dr_ctrl_pkg::*;

    localparam int CNT_MAX = (TIMEOUT > CD_RST_CYC) ? TIMEOUT : CD_RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(CD_RST_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cd_s;

    dr_cd_sync #(
        .STAGES(SYNC_STAGES)
    ) u_cd_sync (
        .clk(clk),
        .rst(rst),
        .d  (cd_q),
        .q  (cd_s)
    );

    // The counter free-runs and is zeroed on every transition, so it always
    // holds the number of cycles already spent in the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CDRST;
            cnt         <= '0;
            dr_in_1     <= '0;
            dr_in_0     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_err     <= 1'b0;
            in_ready    <= 1'b0;
            err_timeout <= 1'b0;
            cd_sdn      <= 1'b0;
            busy        <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
            case (state)
                CDRST: begin
                    if (cnt == RST_LAST) begin
                        cd_sdn <= 1'b1;
                        state  <= WAITSP;
                        cnt    <= '0;
                    end
                end
                WAITSP: begin
                    if (!cd_s) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                        cnt      <= '0;
                    end else if (cnt == TO_LAST) begin
                        state <= ERR;
                        cnt   <= '0;
                    end
                end
                IDLE: begin
                    cnt <= '0;
                    if (in_valid && in_ready) begin
                        dr_in_1  <= IN_W'(dr_encode(DR_MAX_W'(in_data)) >> DR_MAX_W);
                        dr_in_0  <= IN_W'(dr_encode(DR_MAX_W'(in_data)));
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // Completion seen on the last allowed cycle still counts as success.
                    if (cd_s) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state <= ERR;
                        cnt   <= '0;
                    end
                end
                CAPTURE: begin
                    out_data  <= dr_out_1;
                    out_err   <= dr_illegal(DR_MAX_W'(dr_out_1), DR_MAX_W'(dr_out_0));
                    out_valid <= 1'b1;
                    state     <= HOLD;
                    cnt       <= '0;
                end
                HOLD: begin
                    cnt <= '0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        dr_in_1   <= '0;
                        dr_in_0   <= '0;
                        state     <= SPACER;
                    end
                end
                SPACER: begin
                    if (!cd_s) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                        cnt      <= '0;
                    end else if (cnt == TO_LAST) begin
                        state <= ERR;
                        cnt   <= '0;
                    end
                end
                ERR: begin
                    err_timeout <= 1'b1;
                    dr_in_1     <= '0;
                    dr_in_0     <= '0;
                    out_valid   <= 1'b0;
                    cd_sdn      <= 1'b0;
                    state       <= CDRST;
                    cnt         <= '0;
                end
                default: begin
                    state <= CDRST;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dr_handshake_ctrl.sv
// Directed bench for dr_handshake_ctrl with a fixed-delay completion-detector model
// that follows the rails three clocks later.
module tb_dr_handshake_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] dr_in_1;
    logic [15:0] dr_in_0;
    logic        cd_q;
    logic        cd_sdn;
    logic [1:0]  dr_out_1;
    logic [1:0]  dr_out_0;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_data;
    logic        out_err;
    logic        err_timeout;
    logic        err_clr;
    logic        busy;

    logic        det_en;
    logic [2:0]  hist;

    int n_checks;
    int n_pass;
    int n_fail;

    dr_handshake_ctrl #(
        .IN_W       (16),
        .OUT_W      (2),
        .SYNC_STAGES(2),
        .TIMEOUT    (8),
        .CD_RST_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dr_in_1    (dr_in_1),
        .dr_in_0    (dr_in_0),
        .cd_q       (cd_q),
        .cd_sdn     (cd_sdn),
        .dr_out_1   (dr_out_1),
        .dr_out_0   (dr_out_0),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_timeout(err_timeout),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector model: completion follows "any rail driven" three clocks later.
    always @(posedge clk) begin
        hist <= {hist[1:0], |(dr_in_1 | dr_in_0)};
    end
    assign cd_q = det_en & hist[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(in_ready), 1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        hist      = '0;
        det_en    = 1'b1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        dr_out_1  = '0;
        dr_out_0  = '0;

        // Reset and init
        repeat (3) tick();
        check("rst_dr_in_1", 32'(dr_in_1), 0);
        check("rst_dr_in_0", 32'(dr_in_0), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_err_timeout", 32'(err_timeout), 0);
        check("rst_cd_sdn", 32'(cd_sdn), 0);
        check("rst_busy", 32'(busy), 1);
        rst = 1'b0;
        tick();
        check("init_cd_sdn_low", 32'(cd_sdn), 0);
        tick();
        check("init_cd_sdn_high", 32'(cd_sdn), 1);
        check("init_not_ready", 32'(in_ready), 0);
        tick();
        check("init_in_ready", 32'(in_ready), 1);
        check("init_busy", 32'(busy), 0);
        check("init_rails", 32'(dr_in_1 | dr_in_0), 0);

        // Nominal transfer
        dr_out_1 = 2'b10;
        dr_out_0 = 2'b01;
        in_data  = 16'hA5C3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("nom_dr_in_1", 32'(dr_in_1), 'hA5C3);
        check("nom_dr_in_0", 32'(dr_in_0), 'h5A3C);
        check("nom_in_ready_low", 32'(in_ready), 0);
        check("nom_busy", 32'(busy), 1);
        repeat (5) tick();
        check("nom_valid_early", 32'(out_valid), 0);
        tick();
        check("nom_valid_6", 32'(out_valid), 0);
        tick();
        check("nom_valid_7", 32'(out_valid), 1);
        check("nom_out_data", 32'(out_data), 'b10);
        check("nom_out_err", 32'(out_err), 0);

        // Backpressure
        repeat (10) tick();
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_rails_data", 32'(dr_in_1), 'hA5C3);
        check("bp_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_valid_drop", 32'(out_valid), 0);
        check("bp_spacer", 32'(dr_in_1 | dr_in_0), 0);
        check("bp_out_data_hold", 32'(out_data), 'b10);
        repeat (5) tick();
        check("bp_ready_wait", 32'(in_ready), 0);
        tick();
        check("bp_ready_back", 32'(in_ready), 1);

        // Illegal code
        dr_out_1 = 2'b11;
        dr_out_0 = 2'b01;
        in_data  = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ill_dr_in_0", 32'(dr_in_0), 'hEDCB);
        repeat (6) tick();
        check("ill_valid_6", 32'(out_valid), 0);
        tick();
        check("ill_out_valid", 32'(out_valid), 1);
        check("ill_out_data", 32'(out_data), 'b11);
        check("ill_out_err", 32'(out_err), 1);
        check("ill_err_timeout", 32'(err_timeout), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_ready("ill_ready_back", 10);

        // Timeout in DATA
        det_en   = 1'b0;
        in_data  = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("to_rails_on", 32'(dr_in_1), 'hFFFF);
        repeat (7) tick();
        check("to_not_yet", 32'(err_timeout), 0);
        tick();
        check("to_err_state_flag", 32'(err_timeout), 0);
        check("to_err_state_rails", 32'(dr_in_1), 'hFFFF);
        tick();
        check("to_err_timeout", 32'(err_timeout), 1);
        check("to_rails_off", 32'(dr_in_1 | dr_in_0), 0);
        check("to_cd_sdn_low1", 32'(cd_sdn), 0);
        check("to_out_valid", 32'(out_valid), 0);
        tick();
        check("to_cd_sdn_low2", 32'(cd_sdn), 0);
        tick();
        check("to_cd_sdn_high", 32'(cd_sdn), 1);
        check("to_sticky", 32'(err_timeout), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_clr", 32'(err_timeout), 0);
        wait_ready("to_ready_back", 10);
        det_en = 1'b1;

        // Reset mid-operation while in HOLD
        dr_out_1 = 2'b10;
        dr_out_0 = 2'b01;
        in_data  = 16'h0F0F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("mid_hold_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_rails", 32'(dr_in_1 | dr_in_0), 0);
        check("mid_cd_sdn", 32'(cd_sdn), 0);
        check("mid_busy", 32'(busy), 1);
        check("mid_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_cd_sdn_low", 32'(cd_sdn), 0);
        tick();
        check("mid_cd_sdn_high", 32'(cd_sdn), 1);
        wait_ready("mid_ready_back", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
